// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
//   Baud-rate generator for the 16550-compatible UART. It divides clk by the
//   latched divisor (DLM:DLL) to produce an oversample tick. Every OVERSAMPLE
//   oversample ticks it produces a bit tick, and it produces a mid-bit tick
//   when the oversample index reaches OVERSAMPLE/2.
//
//   Optional feature: define UART_BAUD_FRAC_EN to add a fractional divisor.
//   In that build a FRAC_W-bit accumulator stretches some periods to D+1
//   cycles, which gives an average period of D + frac/2^FRAC_W cycles.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   enable    in   run enable; when low, the counters clear synchronously
//   div_we    in   one-cycle divisor load strobe (highest priority)
//   div_i     in   divisor value, sampled when div_we=1
//   frac_i    in   fractional divisor (only when UART_BAUD_FRAC_EN is set)
//   div_o     out  currently latched divisor
//   os_tick   out  one-cycle oversample pulse (BAUDOUT equivalent)
//   bit_tick  out  one-cycle pulse, once per OVERSAMPLE os_ticks
//   mid_tick  out  one-cycle pulse at the half-bit point
//   os_phase  out  current oversample index
//
// Handshake: none. div_we is a single-cycle strobe with no ready/ack; every
// tick output is a registered one-cycle pulse that is always accepted.
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16,  // power of two, 4..32
  parameter int FRAC_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          div_we,
  input  logic [DIV_W-1:0]              div_i,
`ifdef UART_BAUD_FRAC_EN
  input  logic [FRAC_W-1:0]             frac_i,
`endif
  output logic [DIV_W-1:0]              div_o,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             os_q, os_d;
  logic             bit_q, bit_d;
  logic             mid_q, mid_d;
  logic [DIV_W-1:0] term;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [FRAC_W:0]   acc_sum;
`endif

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    os_d    = 1'b0;
    bit_d   = 1'b0;
    mid_d   = 1'b0;
    term    = '0;
`ifdef UART_BAUD_FRAC_EN
    frac_d  = frac_q;
    acc_d   = acc_q;
    ext_d   = ext_q;
    acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
`endif

    if (div_we) begin
      // A divisor load restarts the whole phase from zero.
      div_d   = div_i;
      cnt_d   = '0;
      phase_d = '0;
`ifdef UART_BAUD_FRAC_EN
      frac_d  = frac_i;
      acc_d   = '0;
      ext_d   = 1'b0;
`endif
    end else if (!enable || (div_q == '0)) begin
      // A zero divisor stalls the generator. It is tested before any D-1
      // arithmetic is used, so the terminal count never underflows.
      cnt_d   = '0;
      phase_d = '0;
`ifdef UART_BAUD_FRAC_EN
      acc_d   = '0;
      ext_d   = 1'b0;
`endif
    end else begin
`ifdef UART_BAUD_FRAC_EN
      // A carry from the previous period stretches this period by one cycle.
      term = ext_q ? div_q : (div_q - DIV_W'(1));
`else
      term = div_q - DIV_W'(1);
`endif
      if (cnt_q == term) begin
        cnt_d   = '0;
        os_d    = 1'b1;
        phase_d = phase_q + PH_W'(1);  // OVERSAMPLE is 2^PH_W, so this wraps
        bit_d   = (phase_d == '0);
        mid_d   = (phase_d == PH_HALF);
`ifdef UART_BAUD_FRAC_EN
        acc_d   = acc_sum[FRAC_W-1:0];
        ext_d   = acc_sum[FRAC_W];
`endif
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      os_q    <= 1'b0;
      bit_q   <= 1'b0;
      mid_q   <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
      frac_q  <= '0;
      acc_q   <= '0;
      ext_q   <= 1'b0;
`endif
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      mid_q   <= mid_d;
`ifdef UART_BAUD_FRAC_EN
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      ext_q   <= ext_d;
`endif
    end
  end

  assign div_o    = div_q;
  assign os_tick  = os_q;
  assign bit_tick = bit_q;
  assign mid_tick = mid_q;
  assign os_phase = phase_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_gen
//   Directed bench for uart_baud_gen with hand-computed expected values.
//   Inputs are driven just after the falling edge, and outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_baud_gen;

  localparam int DIV_W  = 16;
  localparam int OS     = 16;
  localparam int FRAC_W = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             div_we;
  logic [DIV_W-1:0] div_i;
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_i;
`endif
  logic [DIV_W-1:0] div_o;
  logic             os_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic [3:0]       os_phase;

  int n_cmp = 0;
  int n_bad = 0;

  uart_baud_gen #(.DIV_W(DIV_W), .OVERSAMPLE(OS), .FRAC_W(FRAC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .div_we   (div_we),
    .div_i    (div_i),
`ifdef UART_BAUD_FRAC_EN
    .frac_i   (frac_i),
`endif
    .div_o    (div_o),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .os_phase (os_phase)
  );

  // clock / reset: 50 ns period
  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       sel = os_tick;
      1:       sel = bit_tick;
      2:       sel = mid_tick;
      default: sel = (os_phase == 4'd7);
    endcase
  endfunction

  // Counts falling edges until the selected condition holds. Returns -1 if
  // the condition does not hold within the limit.
  task automatic wait_ev(input int which, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel(which) && n < limit);
    if (!sel(which)) n = -1;
  endtask

  task automatic load_div(input logic [DIV_W-1:0] d, input logic [FRAC_W-1:0] f);
    enable = 1'b0;
    div_we = 1'b1;
    div_i  = d;
`ifdef UART_BAUD_FRAC_EN
    frac_i = f;
`else
    if (f != '0) $display("note: frac ignored in this build");
`endif
    @(negedge clk);
    div_we = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    int n;
    int ticks;
    rst_n  = 1'b0;
    enable = 1'b0;
    div_we = 1'b0;
    div_i  = '0;
`ifdef UART_BAUD_FRAC_EN
    frac_i = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_div_o", div_o, 0);
    check("rst_os_tick", os_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_mid_tick", mid_tick, 0);
    check("rst_os_phase", os_phase, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // D=130: 130-cycle period, 2080-cycle bit, mid-bit 1040 after bit
    load_div(16'd130, '0);
    wait_ev(0, 400, n);   check("d130_first_tick", n, 130);
    check("d130_div_o", div_o, 130);
    wait_ev(0, 400, n);   check("d130_period", n, 130);
    check("d130_phase2", os_phase, 2);
    wait_ev(1, 3000, n);  check("d130_first_bit", n, 2080 - 260);
    check("d130_bit_with_os", os_tick, 1);
    check("d130_bit_phase0", os_phase, 0);
    @(negedge clk);
    check("d130_bit_single", bit_tick, 0);
    wait_ev(2, 3000, n);  check("d130_mid_after_bit", n, 1040 - 1);
    check("d130_mid_phase8", os_phase, 8);
    wait_ev(1, 3000, n);  check("d130_bit_after_mid", n, 1040);

    // D=1: os_tick every cycle, phase steps every cycle
    load_div(16'd1, '0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("d1_os_tick", os_tick, 1);
      check("d1_phase", os_phase, k % 16);
      check("d1_bit_tick", bit_tick, (k % 16) == 0);
      check("d1_mid_tick", mid_tick, (k % 16) == 8);
    end

    // D=0: stall
    load_div(16'd0, '0);
    ticks = 0;
    repeat (1000) begin
      @(negedge clk);
      if (os_tick || bit_tick || mid_tick || os_phase != 0) ticks++;
    end
    check("d0_no_activity", ticks, 0);
    check("d0_phase", os_phase, 0);

    // reload at phase 7 while running with D=10
    load_div(16'd10, '0);
    wait_ev(3, 200, n);   check("d10_reach_ph7", n, 70);
    div_we = 1'b1;
    div_i  = 16'd4;
    @(negedge clk);
    div_we = 1'b0;
    check("reload_phase", os_phase, 0);
    check("reload_no_tick", os_tick, 0);
    check("reload_div_o", div_o, 4);
    wait_ev(0, 50, n);    check("reload_next_tick", n, 4);

    // asynchronous reset while os_tick is high
    load_div(16'd10, '0);
    wait_ev(0, 50, n);    check("pre_rst_tick", n, 10);
    #5 rst_n = 1'b0;
    #1;
    check("arst_os_tick", os_tick, 0);
    check("arst_bit_tick", bit_tick, 0);
    check("arst_mid_tick", mid_tick, 0);
    check("arst_phase", os_phase, 0);
    check("arst_div_o", div_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_div(16'd10, '0);
    wait_ev(0, 50, n);    check("post_rst_first_tick", n, 10);
    check("post_rst_phase", os_phase, 1);

    // enable dropped for three cycles
    wait_ev(0, 50, n);
    wait_ev(0, 50, n);
    check("pre_drop_phase", os_phase, 3);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_phase", os_phase, 0);
    check("drop_os_tick", os_tick, 0);
    check("drop_div_o", div_o, 10);
    enable = 1'b1;
    wait_ev(0, 50, n);    check("reen_first_tick", n, 10);
    check("reen_phase", os_phase, 1);

`ifdef UART_BAUD_FRAC_EN
    // D=130, frac=3/16: three long periods in sixteen, 2083 cycles in total
    begin
      int total;
      int longs;
      total = 0;
      longs = 0;
      load_div(16'd130, 4'd3);
      wait_ev(0, 400, n); check("frac_first_tick", n, 130);
      for (int k = 0; k < 16; k++) begin
        wait_ev(0, 400, n);
        total += n;
        if (n == 131) longs++;
      end
      check("frac_total", total, 2083);
      check("frac_long_periods", longs, 3);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
